// File: rtl/cmsdk_mybusmatrix_in_stg_if.sv
// Bus-matrix input-stage signal bundle: the slave-side AHB address and response
// signals on the master layer, plus the request/response path to the output stage.
interface cmsdk_mybusmatrix_in_stg_if;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        grant;
    logic        dphase_active;
    logic        readyout_m;
    logic [1:0]  resp_m;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in;
    logic [2:0]  burst_in;
    logic [3:0]  prot_in;
    logic        mastlock_in;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    // Seen from the input stage itself.
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
               HREADYS, grant, dphase_active, readyout_m, resp_m,
        output sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in,
               mastlock_in, HREADYOUTS, HRESPS
    );

    // Seen from whatever drives the input stage (master layer plus output stage).
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
               HREADYS, grant, dphase_active, readyout_m, resp_m,
        input  sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in,
               mastlock_in, HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/cmsdk_mybusmatrix_in_stg.sv
// Bus-matrix input stage: passes an address phase straight through when granted,
// otherwise holds it and stalls the master until the output arbiter grants it.
module cmsdk_mybusmatrix_in_stg (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    cmsdk_mybusmatrix_in_stg_if.slave   bus
);

    logic        new_tran;
    logic        pend_tran;
    logic        load_hold;
    logic [31:0] addr_p0;
    logic [1:0]  trans_p0;
    logic        write_p0;
    logic [2:0]  size_p0;
    logic [2:0]  burst_p0;
    logic [3:0]  prot_p0;
    logic        mastlock_p0;

    assign new_tran  = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    assign load_hold = new_tran & ~bus.grant & ~pend_tran;

    // Hold-flag: a held phase only leaves via grant; responses never drop it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran <= 1'b0;
        end else if (pend_tran && bus.grant) begin
            pend_tran <= 1'b0;
        end else if (new_tran && !bus.grant) begin
            pend_tran <= 1'b1;
        end
    end

    // Stage p0: holding registers, frozen for as long as the phase is pending.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_p0     <= '0;
            trans_p0    <= '0;
            write_p0    <= 1'b0;
            size_p0     <= '0;
            burst_p0    <= '0;
            prot_p0     <= '0;
            mastlock_p0 <= 1'b0;
        end else if (load_hold) begin
            addr_p0     <= bus.HADDRS;
            trans_p0    <= bus.HTRANSS;
            write_p0    <= bus.HWRITES;
            size_p0     <= bus.HSIZES;
            burst_p0    <= bus.HBURSTS;
            prot_p0     <= bus.HPROTS;
            mastlock_p0 <= bus.HMASTLOCKS;
        end
    end

    always_comb begin
        bus.sel_in      = pend_tran | new_tran;
        bus.addr_in     = pend_tran ? addr_p0     : bus.HADDRS;
        bus.trans_in    = pend_tran ? trans_p0    : bus.HTRANSS;
        bus.write_in    = pend_tran ? write_p0    : bus.HWRITES;
        bus.size_in     = pend_tran ? size_p0     : bus.HSIZES;
        bus.burst_in    = pend_tran ? burst_p0    : bus.HBURSTS;
        bus.prot_in     = pend_tran ? prot_p0     : bus.HPROTS;
        bus.mastlock_in = pend_tran ? mastlock_p0 : bus.HMASTLOCKS;
    end

    // An owned data phase reports the output stage; otherwise a pending hold stalls.
    always_comb begin
        bus.HREADYOUTS = 1'b1;
        bus.HRESPS     = 2'b00;
        if (bus.dphase_active) begin
            bus.HREADYOUTS = bus.readyout_m;
            bus.HRESPS     = bus.resp_m;
        end else if (pend_tran) begin
            bus.HREADYOUTS = 1'b0;
        end
    end

endmodule

// File: tb/tb_cmsdk_mybusmatrix_in_stg.sv
// Directed bench for the bus-matrix input stage: hold, grant, data-phase
// passthrough, IDLE/BUSY handling and reset in the middle of a hold.
module tb_cmsdk_mybusmatrix_in_stg;

    logic HCLK;
    logic HRESETn;
    int   n_chk;
    int   n_fail;

    cmsdk_mybusmatrix_in_stg_if bus ();

    cmsdk_mybusmatrix_in_stg dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSELS         = 1'b0;
        bus.HADDRS        = 32'h0;
        bus.HTRANSS       = 2'b00;
        bus.HWRITES       = 1'b0;
        bus.HSIZES        = 3'b000;
        bus.HBURSTS       = 3'b000;
        bus.HPROTS        = 4'b0000;
        bus.HMASTLOCKS    = 1'b0;
        bus.HREADYS       = 1'b1;
        bus.grant         = 1'b0;
        bus.dphase_active = 1'b0;
        bus.readyout_m    = 1'b1;
        bus.resp_m        = 2'b00;
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before the next edge).
    task automatic settle();
        #2;
    endtask

    logic [1:0] rdy_vec [3];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus_idle();
        HRESETn = 1'b0;

        // Reset state
        #3;
        chk("rst_pend", 32'(dut.pend_tran), 32'd0);
        chk("rst_sel", 32'(bus.sel_in), 32'd0);
        chk("rst_ready", 32'(bus.HREADYOUTS), 32'd1);
        chk("rst_resp", 32'(bus.HRESPS), 32'd0);
        step();
        step();
        HRESETn = 1'b1;
        step();

        // Immediate grant: no hold, pass-through same cycle
        bus.HSELS   = 1'b1;
        bus.HTRANSS = 2'b10;
        bus.HADDRS  = 32'h2000_0000;
        bus.grant   = 1'b1;
        settle();
        chk("imm_sel", 32'(bus.sel_in), 32'd1);
        chk("imm_addr", bus.addr_in, 32'h2000_0000);
        chk("imm_ready", 32'(bus.HREADYOUTS), 32'd1);
        step();
        bus_idle();
        settle();
        chk("imm_pend", 32'(dut.pend_tran), 32'd0);
        chk("imm_ready2", 32'(bus.HREADYOUTS), 32'd1);
        step();

        // Blocked then granted, locked transfer
        bus.HSELS      = 1'b1;
        bus.HTRANSS    = 2'b10;
        bus.HADDRS     = 32'h1000_0040;
        bus.HWRITES    = 1'b1;
        bus.HSIZES     = 3'b010;
        bus.HBURSTS    = 3'b011;
        bus.HPROTS     = 4'b0011;
        bus.HMASTLOCKS = 1'b1;
        bus.grant      = 1'b0;
        settle();
        chk("blk_sel0", 32'(bus.sel_in), 32'd1);
        chk("blk_addr0", bus.addr_in, 32'h1000_0040);
        chk("blk_ready0", 32'(bus.HREADYOUTS), 32'd1);
        step();
        // Bus changes; first hold cycle even carries a fresh NONSEQ that must not overwrite the hold
        bus.HADDRS     = 32'hDEAD_0000;
        bus.HWRITES    = 1'b0;
        bus.HSIZES     = 3'b000;
        bus.HBURSTS    = 3'b000;
        bus.HPROTS     = 4'b0000;
        bus.HMASTLOCKS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.HREADYS = (i == 0) ? 1'b1 : 1'b0;
            bus.HTRANSS = (i == 0) ? 2'b10 : 2'b00;
            settle();
            chk($sformatf("hold_addr%0d", i), bus.addr_in, 32'h1000_0040);
            chk($sformatf("hold_ready%0d", i), 32'(bus.HREADYOUTS), 32'd0);
            chk($sformatf("hold_sel%0d", i), 32'(bus.sel_in), 32'd1);
            chk($sformatf("hold_lock%0d", i), 32'(bus.mastlock_in), 32'd1);
            chk($sformatf("hold_ctl%0d", i),
                {22'd0, bus.trans_in, bus.write_in, bus.size_in, bus.burst_in, bus.prot_in},
                {22'd0, 2'b10, 1'b1, 3'b010, 3'b011, 4'b0011});
            step();
        end
        bus.grant = 1'b1;
        settle();
        chk("gnt_addr", bus.addr_in, 32'h1000_0040);
        chk("gnt_lock", 32'(bus.mastlock_in), 32'd1);
        chk("gnt_pend", 32'(dut.pend_tran), 32'd1);
        step();
        bus.grant = 1'b0;
        settle();
        chk("post_pend", 32'(dut.pend_tran), 32'd0);
        chk("post_addr", bus.addr_in, 32'hDEAD_0000);
        chk("post_lock", 32'(bus.mastlock_in), 32'd0);
        chk("post_ready", 32'(bus.HREADYOUTS), 32'd1);
        chk("post_sel", 32'(bus.sel_in), 32'd0);
        bus_idle();
        step();

        // Data-phase passthrough: OKAY with wait states
        rdy_vec[0] = 2'b00;
        rdy_vec[1] = 2'b00;
        rdy_vec[2] = 2'b01;
        bus.dphase_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.readyout_m = rdy_vec[i][0];
            settle();
            chk($sformatf("dp_ready%0d", i), 32'(bus.HREADYOUTS), 32'(rdy_vec[i][0]));
            chk($sformatf("dp_resp%0d", i), 32'(bus.HRESPS), 32'd0);
            step();
        end
        // Two-cycle ERROR
        bus.resp_m     = 2'b01;
        bus.readyout_m = 1'b0;
        settle();
        chk("err1_resp", 32'(bus.HRESPS), 32'd1);
        chk("err1_ready", 32'(bus.HREADYOUTS), 32'd0);
        step();
        bus.readyout_m = 1'b1;
        settle();
        chk("err2_resp", 32'(bus.HRESPS), 32'd1);
        chk("err2_ready", 32'(bus.HREADYOUTS), 32'd1);
        step();
        bus_idle();

        // IDLE / BUSY / unselected / HREADYS low never request
        bus.HSELS   = 1'b1;
        bus.HTRANSS = 2'b00;
        settle();
        chk("idle_sel", 32'(bus.sel_in), 32'd0);
        chk("idle_ready", 32'(bus.HREADYOUTS), 32'd1);
        chk("idle_resp", 32'(bus.HRESPS), 32'd0);
        step();
        bus.HTRANSS = 2'b01;
        settle();
        chk("busy_sel", 32'(bus.sel_in), 32'd0);
        chk("busy_ready", 32'(bus.HREADYOUTS), 32'd1);
        step();
        bus.HSELS   = 1'b0;
        bus.HTRANSS = 2'b10;
        settle();
        chk("nosel_sel", 32'(bus.sel_in), 32'd0);
        step();
        bus.HSELS   = 1'b1;
        bus.HREADYS = 1'b0;
        settle();
        chk("nrdy_sel", 32'(bus.sel_in), 32'd0);
        step();
        chk("nrdy_pend", 32'(dut.pend_tran), 32'd0);
        bus_idle();

        // Hold overlapped with an owned data phase, including ERROR
        bus.HSELS   = 1'b1;
        bus.HTRANSS = 2'b11;
        bus.HADDRS  = 32'h3000_0008;
        step();
        bus_idle();
        bus.dphase_active = 1'b1;
        bus.readyout_m    = 1'b0;
        bus.resp_m        = 2'b01;
        settle();
        chk("ovl_ready", 32'(bus.HREADYOUTS), 32'd0);
        chk("ovl_resp", 32'(bus.HRESPS), 32'd1);
        step();
        bus.readyout_m = 1'b1;
        settle();
        chk("ovl_ready_dp", 32'(bus.HREADYOUTS), 32'd1);
        step();
        bus.dphase_active = 1'b0;
        bus.resp_m        = 2'b00;
        settle();
        chk("ovl_pend", 32'(dut.pend_tran), 32'd1);
        chk("ovl_addr", bus.addr_in, 32'h3000_0008);
        chk("ovl_trans", 32'(bus.trans_in), 32'd3);
        chk("ovl_ready_hold", 32'(bus.HREADYOUTS), 32'd0);

        // Reset pulse mid-hold discards the held phase immediately
        bus.HSELS  = 1'b1;
        bus.HADDRS = 32'h55AA_0000;
        #1;
        HRESETn = 1'b0;
        #1;
        chk("rsth_pend", 32'(dut.pend_tran), 32'd0);
        chk("rsth_addr", bus.addr_in, 32'h55AA_0000);
        chk("rsth_sel", 32'(bus.sel_in), 32'd0);
        chk("rsth_ready", 32'(bus.HREADYOUTS), 32'd1);
        step();
        HRESETn = 1'b1;
        step();
        settle();
        chk("rstr_sel", 32'(bus.sel_in), 32'd0);
        chk("rstr_pend", 32'(dut.pend_tran), 32'd0);
        chk("rstr_trans", 32'(bus.trans_in), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
